// File: rtl/store_unit_if.sv
// Store request handshake and word-memory port bundle between a requester/memory
// pair and the store unit.
interface store_unit_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [AWIDTH-1:0] req_addr_i;
  logic [DWIDTH-1:0] req_data_i;
  logic [1:0]        req_size_i;
  logic              done_o;
  logic              err_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_size_i, mem_data_i,
    output req_ready_o, done_o, err_o, mem_addr_o, mem_data_o,
           mem_read_en_o, mem_write_en_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_size_i, mem_data_i,
    input  req_ready_o, done_o, err_o, mem_addr_o, mem_data_o,
           mem_read_en_o, mem_write_en_o
  );
endinterface

// File: rtl/store_unit.sv
// Byte/halfword/word store initiator for a word-only memory; sub-word stores are
// performed as aligned little-endian read-modify-write sequences.
module store_unit #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  state_t            state_reg, state_next;
  logic [AWIDTH-1:0] addr_reg;
  logic [15:0]       data_reg;
  logic [1:0]        size_reg;
  logic [DWIDTH-1:0] wdata_reg;
  logic              err_reg;

  logic              handshake;
  logic              misaligned;
  logic [AWIDTH-1:0] aligned_addr;
  logic [DWIDTH-1:0] merge_word;

  assign handshake    = bus.req_valid_i && bus.req_ready_o;
  assign aligned_addr = {addr_reg[AWIDTH-1:2], 2'b00};

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size_i)
      2'd1:    misaligned = bus.req_addr_i[0];
      2'd2:    misaligned = |bus.req_addr_i[1:0];
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Each byte lane takes new data only if the latched store covers it; a halfword
  // lane pair takes the low byte in its even lane and the high byte in its odd lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic lane_hit;
      logic [7:0] lane_data;
      assign lane_hit  = (size_reg == 2'd0) ? (addr_reg[1:0] == LANE)
                                            : (addr_reg[1] == LANE[1]);
      assign lane_data = (size_reg == 2'd0) ? data_reg[7:0]
                                            : data_reg[8*(gi%2) +: 8];
      assign merge_word[8*gi +: 8] = lane_hit ? lane_data : bus.mem_data_i[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        addr_reg <= bus.req_addr_i;
        data_reg <= bus.req_data_i[15:0];
        size_reg <= bus.req_size_i;
        err_reg  <= misaligned;
        if (bus.req_size_i == 2'd2)
          wdata_reg <= bus.req_data_i;
      end
      if (state_reg == MERGE)
        wdata_reg <= merge_word;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          if (misaligned)                   state_next = RESP;
          else if (bus.req_size_i == 2'd2)  state_next = WRITE;
          else                              state_next = READ;
        end
      end
      READ:    state_next = MERGE;
      MERGE:   state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is forced low during reset so a WRITE cycle hit by reset never commits.
  always_comb begin
    bus.req_ready_o    = 1'b0;
    bus.done_o         = 1'b0;
    bus.err_o          = 1'b0;
    bus.mem_addr_o     = '0;
    bus.mem_data_o     = '0;
    bus.mem_read_en_o  = 1'b0;
    bus.mem_write_en_o = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: bus.req_ready_o = 1'b1;
        READ: begin
          bus.mem_read_en_o = 1'b1;
          bus.mem_addr_o    = aligned_addr;
        end
        WRITE: begin
          bus.mem_write_en_o = 1'b1;
          bus.mem_addr_o     = aligned_addr;
          bus.mem_data_o     = wdata_reg;
        end
        RESP: begin
          bus.done_o = 1'b1;
          bus.err_o  = err_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: word-memory responder, byte-array reference
// model with a per-cycle output compare, directed cases and randomized traffic.
module tb_store_unit;

  localparam int WORDS = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_unit_if #(.AWIDTH(32), .DWIDTH(32)) bus();

  store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] tb_mem [WORDS];
  logic [31:0] rd_q;
  logic [7:0]  ref_mem [WORDS*4];

  // reference model state for the one request in flight
  bit          act = 1'b0;
  int          k, kind, wk, lk;
  logic [31:0] p_addr, p_word;

  assign bus.mem_data_i = rd_q;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    if (i == 128 || i == 132 || i == 136) return 32'h1122_3344;
    return (v * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act_v, exp_v);
    end
  endtask

  function automatic logic [31:0] ref_word(input int byte_addr);
    return {ref_mem[byte_addr+3], ref_mem[byte_addr+2], ref_mem[byte_addr+1], ref_mem[byte_addr]};
  endfunction

  // memory block: registered read, write on the rising edge
  initial begin
    for (int i = 0; i < WORDS; i++) tb_mem[i] = init_word(i);
    rd_q = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_write_en_o) tb_mem[bus.mem_addr_o[10:2]] = bus.mem_data_o;
      if (bus.mem_read_en_o)  rd_q <= tb_mem[bus.mem_addr_o[10:2]];
    end
  end

  // per-cycle compare against the model, then advance the model across the next edge
  initial begin
    logic e_ready, e_re, e_we, e_done, e_err, chk_addr;
    logic [31:0] e_addr, e_data;
    for (int i = 0; i < WORDS; i++) begin
      logic [31:0] w;
      w = init_word(i);
      for (int j = 0; j < 4; j++) ref_mem[4*i+j] = w[8*j +: 8];
    end
    forever begin
      @(negedge clk);
      e_ready  = !rst && !act;
      e_re     = !rst && act && kind == 2 && k == 1;
      e_we     = !rst && act && k == wk;
      e_done   = !rst && act && k == lk;
      e_err    = e_done && kind == 0;
      chk_addr = !(act && !rst && kind == 2 && k == 2);
      e_addr   = (e_re || e_we) ? p_addr : 32'h0;
      e_data   = e_we ? p_word : 32'h0;
      chk("req_ready", {31'b0, bus.req_ready_o}, {31'b0, e_ready});
      chk("read_en", {31'b0, bus.mem_read_en_o}, {31'b0, e_re});
      chk("write_en", {31'b0, bus.mem_write_en_o}, {31'b0, e_we});
      chk("done", {31'b0, bus.done_o}, {31'b0, e_done});
      chk("err", {31'b0, bus.err_o}, {31'b0, e_err});
      chk("mem_data_o", bus.mem_data_o, e_data);
      if (chk_addr) chk("mem_addr_o", bus.mem_addr_o, e_addr);

      if (rst) begin
        act = 1'b0;
      end else if (act) begin
        if (k == wk)
          for (int j = 0; j < 4; j++) ref_mem[p_addr+j] = p_word[8*j +: 8];
        if (k == lk) act = 1'b0;
        else k++;
      end else if (bus.req_valid_i) begin
        logic [10:0] a;
        logic [1:0]  s;
        logic [7:0]  b [4];
        bit mis;
        a   = bus.req_addr_i[10:0];
        s   = bus.req_size_i;
        mis = (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || s == 2'd3;
        p_addr = {21'b0, a[10:2], 2'b00};
        kind   = mis ? 0 : (s == 2'd2 ? 1 : 2);
        wk     = (kind == 1) ? 1 : (kind == 2 ? 3 : -1);
        lk     = (kind == 0) ? 1 : (kind == 1 ? 2 : 4);
        if (kind == 1) begin
          p_word = bus.req_data_i;
        end else begin
          for (int j = 0; j < 4; j++) b[j] = ref_mem[p_addr+j];
          b[a[1:0]] = bus.req_data_i[7:0];
          if (s == 2'd1) b[a[1:0]+2'd1] = bus.req_data_i[15:8];
          p_word = {b[3], b[2], b[1], b[0]};
        end
        act = 1'b1;
        k   = 1;
      end
    end
  end

  // returns at posedge+1 of the cycle after the handshake edge
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input bit hold);
    bit got;
    got = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_data_i  = d;
    bus.req_size_i  = s;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = bus.req_ready_o;
      @(posedge clk);
      #1;
    end
    if (!got) chk("handshake_timeout", 32'h0, 32'h1);
    if (!hold) begin
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = $urandom;
      bus.req_data_i  = $urandom;
      bus.req_size_i  = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 20 && !idle; n++) begin
      if (!act) idle = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!idle) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  task automatic rand_req(output logic [31:0] a, output logic [31:0] d, output logic [1:0] s);
    s = 2'($urandom_range(0, 3));
    a = 32'($urandom_range(0, 32'h7FF));
    if ($urandom_range(0, 3) != 0) begin
      if (s == 2'd1) a[0] = 1'b0;
      if (s == 2'd2) a[1:0] = 2'b00;
    end
    d = $urandom;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    int bad;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_size_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, bus.req_ready_o}, 32'h1);
    @(posedge clk);
    #1;

    send(32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0);
    wait_idle();
    chk("word_store_mem", tb_mem[64], 32'hDEAD_BEEF);
    chk("word_store_ref", ref_word(32'h100), 32'hDEAD_BEEF);

    send(32'h202, 32'h0000_00AB, 2'd0, 1'b0);
    wait_idle();
    chk("byte_store_mem", tb_mem[128], 32'h11AB_3344);
    chk("byte_store_ref", ref_word(32'h200), 32'h11AB_3344);

    send(32'h212, 32'h0000_CAFE, 2'd1, 1'b0);
    wait_idle();
    chk("half_hi_mem", tb_mem[132], 32'hCAFE_3344);

    send(32'h220, 32'h0000_CAFE, 2'd1, 1'b0);
    wait_idle();
    chk("half_lo_mem", tb_mem[136], 32'h1122_CAFE);

    send(32'h301, 32'h1111_1111, 2'd1, 1'b0);
    wait_idle();
    send(32'h302, 32'h2222_2222, 2'd2, 1'b0);
    wait_idle();
    send(32'h300, 32'h3333_3333, 2'd3, 1'b0);
    wait_idle();
    chk("misaligned_untouched", tb_mem[192], init_word(192));

    send(32'h400, 32'h0000_005A, 2'd0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", {31'b0, bus.req_ready_o}, 32'h1);
    chk("mid_reset_no_commit", tb_mem[256], init_word(256));
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      rand_req(a, d, s);
      send(a, d, s, 1'b1);
    end
    bus.req_valid_i = 1'b0;
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rand_req(a, d, s);
      send(a, d, s, 1'b0);
    end
    wait_idle();
    @(posedge clk);
    #1;

    bad = 0;
    for (int i = 0; i < WORDS; i++)
      if (tb_mem[i] !== ref_word(4*i)) bad++;
    chk("final_mem_mismatch_words", 32'(bad), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
